muldiv_sequencer: RTL and testbench

- Iterative multiply/divide sequencer for the execution stage. It owns the HI/LO registers and runs MULT/MULTU/DIV/DIVU over WIDTH cycles, one bit per cycle.
- Stalls the pipeline when a younger instruction needs HI/LO, or needs the unit, while an operation is in flight.
- Started by the EX-stage decode of funct codes 011000–011011, alongside the ALU control decode.

---
 rtl/muldiv_sequencer_if.sv | 29 ++
 rtl/muldiv_sequencer.sv | 160 ++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_sequencer_if.sv
// Pipeline-facing bundle of the multiply/divide sequencer: request, operands,
// HI/LO moves, flush, and the HI/LO / status outputs.
interface muldiv_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic [1:0]       op_i;
  logic [WIDTH-1:0] rs_i;
  logic [WIDTH-1:0] rt_i;
  logic             mf_req_i;
  logic             mthi_i;
  logic             mtlo_i;
  logic             flush_i;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;
  logic             busy_o;
  logic             done_o;
  logic             stall_o;

  modport master (
    output start_i, op_i, rs_i, rt_i, mf_req_i, mthi_i, mtlo_i, flush_i,
    input  hi_o, lo_o, busy_o, done_o, stall_o
  );

  modport slave (
    input  start_i, op_i, rs_i, rt_i, mf_req_i, mthi_i, mtlo_i, flush_i,
    output hi_o, lo_o, busy_o, done_o, stall_o
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO, one bit per cycle.
// Optional MULDIV_EARLY_OUT_EN: multiply finishes once the remaining multiplier bits are zero.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  muldiv_sequencer_if.slave   bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, SIGN} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;    // product, or quotient in the low half
  logic [2*WIDTH-1:0] opnd_q, opnd_d;  // shifted multiplicand, or divisor in the low half
  logic [WIDTH-1:0]   mplr_q, mplr_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               rneg_q, rneg_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               signed_op;
  logic [WIDTH-1:0]   rs_mag, rt_mag;
  logic [WIDTH:0]     rem_sh;
  logic               rem_ge;
  logic [WIDTH-1:0]   rem_sub;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    mplr_d    = mplr_q;
    rem_d     = rem_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rneg_d    = rneg_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    signed_op = ~bus.op_i[0];
    rs_mag    = (signed_op && bus.rs_i[WIDTH-1]) ? -bus.rs_i : bus.rs_i;
    rt_mag    = (signed_op && bus.rt_i[WIDTH-1]) ? -bus.rt_i : bus.rt_i;

    // Restoring divide step: bring in the next dividend bit, subtract if it fits.
    rem_sh    = {rem_q, acc_q[WIDTH-1]};
    rem_ge    = rem_sh >= {1'b0, opnd_q[WIDTH-1:0]};
    rem_sub   = rem_sh[WIDTH-1:0] - opnd_q[WIDTH-1:0];

    prod_fix  = neg_q  ? -acc_q : acc_q;
    quot_fix  = neg_q  ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix   = rneg_q ? -rem_q : rem_q;

    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          is_div_d = bus.op_i[1];
          neg_d    = signed_op & (bus.rs_i[WIDTH-1] ^ bus.rt_i[WIDTH-1]);
          rneg_d   = signed_op & bus.rs_i[WIDTH-1];
          rem_d    = '0;
          mplr_d   = rt_mag;
          cnt_d    = CW'(WIDTH - 1);
          state_d  = CALC;
          if (bus.op_i[1]) begin
            acc_d  = {{WIDTH{1'b0}}, rs_mag};
            opnd_d = {{WIDTH{1'b0}}, rt_mag};
          end else begin
            acc_d  = '0;
            opnd_d = {{WIDTH{1'b0}}, rs_mag};
`ifdef MULDIV_EARLY_OUT_EN
            if (rt_mag == '0) state_d = SIGN;
`endif
          end
        end else begin
          // A move issued together with start is a decode error and is dropped.
          if (bus.mthi_i) hi_d = bus.rs_i;
          if (bus.mtlo_i) lo_d = bus.rs_i;
        end
      end

      CALC: begin
        cnt_d = cnt_q - 1'b1;
        if (is_div_q) begin
          rem_d = rem_ge ? rem_sub : rem_sh[WIDTH-1:0];
          acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], rem_ge};
        end else begin
          acc_d  = acc_q + (mplr_q[0] ? opnd_q : '0);
          opnd_d = opnd_q << 1;
          mplr_d = mplr_q >> 1;
        end
        if (cnt_q == '0) state_d = SIGN;
`ifdef MULDIV_EARLY_OUT_EN
        if (!is_div_q && (mplr_q[WIDTH-1:1] == '0)) state_d = SIGN;
`endif
      end

      SIGN: begin
        state_d = IDLE;
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quot_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
      end

      default: state_d = IDLE;
    endcase

    // Flush wins over everything, including the SIGN-cycle write.
    if (bus.flush_i) begin
      state_d = IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      mplr_q   <= '0;
      rem_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      mplr_q   <= mplr_d;
      rem_q    <= rem_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign bus.hi_o    = hi_q;
  assign bus.lo_o    = lo_q;
  assign bus.busy_o  = (state_q != IDLE);
  assign bus.done_o  = (state_q == SIGN) && !bus.flush_i;
  // Released during done so a dependent MFHI/MFLO reads the new HI/LO next cycle.
  assign bus.stall_o = bus.busy_o && !bus.done_o &&
                       (bus.start_i || bus.mf_req_i || bus.mthi_i || bus.mtlo_i);
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: stimulus pushes expected HI/LO and latency,
// a monitor pops on every done_o and compares.
module tb_muldiv_sequencer;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] rs;
    logic [W-1:0] rt;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           lat;
    int           start_cyc;
  } exp_t;

  exp_t exp_q[$];

  muldiv_sequencer_if #(.WIDTH(W)) bus ();
  muldiv_sequencer #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: signed ops work on magnitudes, then the result signs are applied.
  function automatic exp_t model(logic [1:0] op, logic [W-1:0] rs, logic [W-1:0] rt);
    exp_t e;
    logic sg;
    logic [63:0] p;
    logic [W-1:0] a, b, q, r;
    int hb;
    sg = ~op[0];
    e.op = op; e.rs = rs; e.rt = rt; e.start_cyc = 0;
    a = (sg && rs[W-1]) ? -rs : rs;
    b = (sg && rt[W-1]) ? -rt : rt;
    e.lat = W + 1;
    if (!op[1]) begin
      p = {32'b0, a} * {32'b0, b};
      if (sg && (rs[W-1] ^ rt[W-1])) p = -p;
      e.hi = p[63:32];
      e.lo = p[31:0];
`ifdef MULDIV_EARLY_OUT_EN
      hb = -1;
      for (int i = 0; i < W; i++) if (b[i]) hb = i;
      e.lat = hb + 2;
`endif
    end else begin
      if (b == 0) begin
        q = '1;
        r = a;
      end else begin
        q = a / b;
        r = a % b;
      end
      e.lo = (sg && (rs[W-1] ^ rt[W-1])) ? -q : q;
      e.hi = (sg && rs[W-1]) ? -r : r;
    end
    return e;
  endfunction

  task automatic issue(logic [1:0] op, logic [W-1:0] rs, logic [W-1:0] rt, bit push,
                       bit use_k, logic [W-1:0] k_hi, logic [W-1:0] k_lo);
    exp_t e;
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.op_i    = op;
    bus.rs_i    = rs;
    bus.rt_i    = rt;
    if (push) begin
      e = model(op, rs, rt);
      if (use_k) begin
        e.hi = k_hi;
        e.lo = k_lo;
      end
      e.start_cyc = cyc;
      exp_q.push_back(e);
    end
    @(negedge clk);
    bus.start_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", {63'b0, bus.busy_o}, 64'd0);
    @(negedge clk);
  endtask

  task automatic write_reg(bit to_hi, logic [W-1:0] v);
    @(negedge clk);
    bus.rs_i   = v;
    bus.mthi_i = to_hi;
    bus.mtlo_i = !to_hi;
    @(negedge clk);
    bus.mthi_i = 1'b0;
    bus.mtlo_i = 1'b0;
  endtask

  initial begin : monitor
    exp_t cur;
    bit pend = 1'b0;
    forever begin
      @(negedge clk);
      if (pend) begin
        check("hi", bus.hi_o, cur.hi);
        check("lo", bus.lo_o, cur.lo);
        $display("op=%0d rs=%h rt=%h -> hi=%h lo=%h", cur.op, cur.rs, cur.rt, bus.hi_o, bus.lo_o);
        pend = 1'b0;
      end
      if (rst_n && bus.done_o) begin
        if (exp_q.size() == 0) begin
          check("spurious_done", 64'd1, 64'd0);
        end else begin
          cur = exp_q.pop_front();
          check("latency", 64'(cyc - cur.start_cyc), 64'(cur.lat));
          pend = 1'b1;
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    exp_t e4;
    logic [1:0]   op;
    logic [W-1:0] rs, rt;
    bus.start_i = 0; bus.op_i = 0; bus.rs_i = 0; bus.rt_i = 0;
    bus.mf_req_i = 0; bus.mthi_i = 0; bus.mtlo_i = 0; bus.flush_i = 0;

    repeat (3) @(negedge clk);
    check("rst_busy", {63'b0, bus.busy_o}, 0);
    check("rst_done", {63'b0, bus.done_o}, 0);
    check("rst_stall", {63'b0, bus.stall_o}, 0);
    check("rst_hi", bus.hi_o, 0);
    check("rst_lo", bus.lo_o, 0);
    rst_n = 1'b1;

    write_reg(1'b1, 32'hAAAA5555);
    write_reg(1'b0, 32'h00001234);
    check("mthi", bus.hi_o, 32'hAAAA5555);
    check("mtlo", bus.lo_o, 32'h00001234);

    // Reset in the middle of a DIV discards it.
    issue(2'b10, 32'd1000, 32'd3, 1'b0, 1'b0, 0, 0);
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", {63'b0, bus.busy_o}, 0);
    check("midrst_hi", bus.hi_o, 0);
    check("midrst_lo", bus.lo_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("midrst_idle", {63'b0, bus.busy_o}, 0);
    check("midrst_hi_kept", bus.hi_o, 0);

    issue(2'b00, 32'hFFFFFFFE, 32'h3, 1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFA);
    wait_idle();
    issue(2'b01, 32'hFFFFFFFE, 32'h3, 1'b1, 1'b1, 32'h00000002, 32'hFFFFFFFA);
    wait_idle();
    issue(2'b10, 32'hFFFFFFF9, 32'h2, 1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD);
    wait_idle();
    issue(2'b11, 32'h7, 32'h0, 1'b1, 1'b1, 32'h7, 32'hFFFFFFFF);
    wait_idle();
    issue(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h0, 32'h80000000);
    wait_idle();

    // MFHI hazard: stall held until the done cycle.
    e4 = model(2'b01, 32'd5, 32'd6);
    issue(2'b01, 32'd5, 32'd6, 1'b1, 1'b1, 32'd0, 32'd30);
    bus.mf_req_i = 1'b1;
    for (int k = 1; k <= e4.lat; k++) begin
      #1;
      check($sformatf("stall_c%0d", k), {63'b0, bus.stall_o}, (k < e4.lat) ? 64'd1 : 64'd0);
      if (k < e4.lat) @(negedge clk);
    end
    bus.mf_req_i = 1'b0;
    wait_idle();
    check("mfhi_lo", bus.lo_o, 32'd30);

    // Flush mid-DIVU leaves HI/LO untouched.
    write_reg(1'b1, 32'h11);
    write_reg(1'b0, 32'h22);
    issue(2'b11, 32'd100, 32'd7, 1'b0, 1'b0, 0, 0);
    repeat (4) @(negedge clk);
    bus.start_i = 1'b1;
    #1;
    check("busy_start_stall", {63'b0, bus.stall_o}, 1);
    bus.start_i = 1'b0;
    bus.flush_i = 1'b1;
    @(negedge clk);
    bus.flush_i = 1'b0;
    #1;
    check("flush_busy", {63'b0, bus.busy_o}, 0);
    check("flush_hi", bus.hi_o, 32'h11);
    check("flush_lo", bus.lo_o, 32'h22);
    issue(2'b11, 32'd100, 32'd7, 1'b1, 1'b1, 32'd2, 32'd14);
    wait_idle();

    // MTHI alongside start is dropped; start proceeds.
    write_reg(1'b1, 32'h55);
    bus.mthi_i = 1'b1;
    issue(2'b01, 32'd9, 32'd3, 1'b1, 1'b1, 32'd0, 32'd27);
    bus.mthi_i = 1'b0;
    check("mthi_dropped", bus.hi_o, 32'h55);
    wait_idle();

    for (int n = 0; n < 40; n++) begin
      op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: rt = 32'd0;
        1: rt = 32'($urandom_range(0, 15));
        2: rt = -32'($urandom_range(1, 15));
        default: rt = $urandom;
      endcase
      rs = ($urandom_range(0, 4) == 0) ? 32'h80000000 : $urandom;
      issue(op, rs, rt, 1'b1, 1'b0, 0, 0);
      wait_idle();
    end

    repeat (5) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
